// File: rtl/frame_uart_writer_pkg.sv
// Shared types and defaults for the frame-to-UART byte serialiser.
package frame_uart_writer_pkg;

  localparam int DEF_DATA_IN_BUS_SIZE = 56;
  localparam int DEF_UART_BUS_SIZE    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/frame_uart_writer_if.sv
// Producer-side frame handshake plus UART byte handshake of the frame writer.
interface frame_uart_writer_if
  import frame_uart_writer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_IN_BUS_SIZE,
  parameter int UART_W = DEF_UART_BUS_SIZE
);
  logic              start_wr;
  logic [DATA_W-1:0] data_wr;
  logic              tx_done;
  logic              tx_start;
  logic [UART_W-1:0] tx_data;
  logic              wr_end;
  logic              busy;

  modport master (
    output start_wr, data_wr, tx_done,
    input  tx_start, tx_data, wr_end, busy
  );

  modport slave (
    input  start_wr, data_wr, tx_done,
    output tx_start, tx_data, wr_end, busy
  );
endinterface

// File: rtl/frame_uart_writer.sv
// Serialises one wide debug frame MSB-byte-first onto a UART byte interface.
// Define FRAME_UART_WRITER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module frame_uart_writer
  import frame_uart_writer_pkg::*;
#(
  parameter int DATA_IN_BUS_SIZE = DEF_DATA_IN_BUS_SIZE,
  parameter int UART_BUS_SIZE    = DEF_UART_BUS_SIZE
)(
  input  logic                i_clk,
  input  logic                i_reset,
  frame_uart_writer_if.slave  bus
);

  localparam int NUM_BYTES = DATA_IN_BUS_SIZE / UART_BUS_SIZE;
`ifdef FRAME_UART_WRITER_CHECKSUM_EN
  localparam int NUM_TX = NUM_BYTES + 1;
`else
  localparam int NUM_TX = NUM_BYTES;
`endif
  localparam int                  CNT_SIZE = $clog2(NUM_TX + 1);
  localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(NUM_TX - 1);

  state_e                      state, state_nxt;
  logic                        start_q, start_rise;
  logic [DATA_IN_BUS_SIZE-1:0] shreg, shreg_nxt;
  logic [CNT_SIZE-1:0]         cnt, cnt_nxt;
  logic [UART_BUS_SIZE-1:0]    top_byte, send_byte;
  logic [UART_BUS_SIZE-1:0]    tx_data_q, tx_data_nxt;
  logic                        tx_start_q, tx_start_nxt;
  logic                        wr_end_q, wr_end_nxt;
  logic                        busy_q, busy_nxt;

  // start_q tracks the input every cycle, so a level held through a frame never re-arms
  assign start_rise = bus.start_wr & ~start_q;
  assign top_byte   = shreg[DATA_IN_BUS_SIZE-1 -: UART_BUS_SIZE];

`ifdef FRAME_UART_WRITER_CHECKSUM_EN
  logic [UART_BUS_SIZE-1:0] csum, csum_nxt;

  assign send_byte = (cnt == LAST_CNT) ? csum : top_byte;

  always_comb begin
    csum_nxt = csum;
    if (state == ST_IDLE && start_rise)
      csum_nxt = '0;
    else if (state == ST_SEND && cnt != LAST_CNT)
      csum_nxt = csum ^ top_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) csum <= '0;
    else         csum <= csum_nxt;
  end
`else
  assign send_byte = top_byte;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_rise) state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_WAIT;
      ST_WAIT: if (bus.tx_done) state_nxt = (cnt == LAST_CNT) ? ST_DONE : ST_SEND;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_q;
    wr_end_nxt   = 1'b0;
    busy_nxt     = busy_q;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start_rise) begin
          shreg_nxt = bus.data_wr;
          busy_nxt  = 1'b1;
        end
      end
      ST_SEND: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = send_byte;
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          shreg_nxt = shreg << UART_BUS_SIZE;
          cnt_nxt   = cnt + CNT_SIZE'(1);
        end
      end
      ST_DONE: begin
        wr_end_nxt = 1'b1;
        busy_nxt   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      start_q    <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wr_end_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      start_q    <= bus.start_wr;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
      wr_end_q   <= wr_end_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.wr_end   = wr_end_q;
  assign bus.busy     = busy_q;

endmodule
